// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the EX-stage branch resolution unit: datapath width,
// funct3 branch condition codes and controller state encodings.
package branch_resolve_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] BR_COND_BEQ  = 3'b000;
  localparam logic [2:0] BR_COND_BNE  = 3'b001;
  localparam logic [2:0] BR_COND_BLT  = 3'b100;
  localparam logic [2:0] BR_COND_BGE  = 3'b101;
  localparam logic [2:0] BR_COND_BLTU = 3'b110;
  localparam logic [2:0] BR_COND_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BRC_ST_IDLE     = 2'd0,
    BRC_ST_WAIT     = 2'd1,
    BRC_ST_REDIRECT = 2'd2
  } brc_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode/operand/fetch-facing signal bundle of the branch resolution unit.
// The slave modport is the unit itself; master is whoever drives it.
interface branch_resolve_ctrl_if;
  import branch_resolve_ctrl_pkg::*;

  logic            br_valid;
  logic            br_ready;
  logic            br_is_jalr;
  logic [2:0]      br_cond;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_rdy;
  logic            rs2_rdy;
  logic            kill;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            misalign_valid;
  logic [XLEN-1:0] misalign_addr;
  logic            done;

  modport slave (
    input  br_valid, br_is_jalr, br_cond, br_pc, br_imm,
    input  rs1_val, rs2_val, rs1_rdy, rs2_rdy, kill, redirect_ready,
    output br_ready, redirect_valid, redirect_pc, flush,
    output misalign_valid, misalign_addr, done
  );

  modport master (
    output br_valid, br_is_jalr, br_cond, br_pc, br_imm,
    output rs1_val, rs2_val, rs1_rdy, rs2_rdy, kill, redirect_ready,
    input  br_ready, redirect_valid, redirect_pc, flush,
    input  misalign_valid, misalign_addr, done
  );

endinterface

// File: rtl/branch_resolve_ctrl_cmp.sv
// Branch condition comparator (branch_cmp): purely combinational evaluation of
// a funct3 condition; reserved codes evaluate as not taken.
module branch_resolve_ctrl_cmp
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      cond_i,
  output logic            taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      BR_COND_BEQ:  taken_o = (a_i == b_i);
      BR_COND_BNE:  taken_o = (a_i != b_i);
      BR_COND_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
      BR_COND_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
      BR_COND_BLTU: taken_o = (a_i <  b_i);
      BR_COND_BGEU: taken_o = (a_i >= b_i);
      default:      taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch/JALR resolution: waits for late operands, checks the static
// prediction and issues a redirect on mispredict. Optional perf counters: ARCHER_BR_PERF_EN.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]      perf_branches,
  output logic [CNT_W-1:0]      perf_mispred
);

  brc_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d, misalign_addr_q, misalign_addr_d;
  logic [2:0]      cond_q, cond_d;
  logic            jalr_q, jalr_d, pred_q, pred_d;
  logic            rs1_cap_q, rs1_cap_d, rs2_cap_q, rs2_cap_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic            done_q, done_d, misalign_valid_q, misalign_valid_d;

  logic [XLEN-1:0] rs1_eff, rs2_eff, jalr_sum, target, fall_through;
  logic            rs1_have, rs2_have, cmp_taken, taken, handshake;

  // Operands arriving this cycle count as captured so resolution costs no extra cycle.
  assign rs1_eff      = rs1_cap_q ? rs1_q : bus.rs1_val;
  assign rs2_eff      = rs2_cap_q ? rs2_q : bus.rs2_val;
  assign rs1_have     = rs1_cap_q | bus.rs1_rdy;
  assign rs2_have     = jalr_q | rs2_cap_q | bus.rs2_rdy;
  assign jalr_sum     = rs1_eff + imm_q;
  assign target       = jalr_q ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
  assign fall_through = pc_q + XLEN'(4);
  assign taken        = jalr_q | cmp_taken;
  assign handshake    = (state_q == BRC_ST_REDIRECT) && bus.redirect_ready && !bus.kill;

  branch_resolve_ctrl_cmp u_cmp (
    .a_i     (rs1_eff),
    .b_i     (rs2_eff),
    .cond_i  (cond_q),
    .taken_o (cmp_taken)
  );

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    imm_d            = imm_q;
    cond_d           = cond_q;
    jalr_d           = jalr_q;
    pred_d           = pred_q;
    rs1_d            = rs1_q;
    rs2_d            = rs2_q;
    rs1_cap_d        = rs1_cap_q;
    rs2_cap_d        = rs2_cap_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    misalign_addr_d  = misalign_addr_q;
    done_d           = 1'b0;
    misalign_valid_d = 1'b0;

    case (state_q)
      BRC_ST_IDLE: begin
        if (bus.br_valid) begin
          pc_d      = bus.br_pc;
          imm_d     = bus.br_imm;
          cond_d    = bus.br_cond;
          jalr_d    = bus.br_is_jalr;
          pred_d    = (PRED_MODE != 0) && bus.br_imm[XLEN-1] && !bus.br_is_jalr;
          rs1_cap_d = 1'b0;
          rs2_cap_d = 1'b0;
          state_d   = BRC_ST_WAIT;
        end
      end
      BRC_ST_WAIT: begin
        if (bus.rs1_rdy && !rs1_cap_q) begin
          rs1_d     = bus.rs1_val;
          rs1_cap_d = 1'b1;
        end
        if (bus.rs2_rdy && !rs2_cap_q && !jalr_q) begin
          rs2_d     = bus.rs2_val;
          rs2_cap_d = 1'b1;
        end
        if (rs1_have && rs2_have) begin
          if (taken && (target[1:0] != 2'b00)) begin
            misalign_valid_d = 1'b1;
            misalign_addr_d  = target;
            done_d           = 1'b1;
            state_d          = BRC_ST_IDLE;
          end else if (jalr_q || (taken != pred_q)) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = taken ? target : fall_through;
            state_d          = BRC_ST_REDIRECT;
          end else begin
            done_d  = 1'b1;
            state_d = BRC_ST_IDLE;
          end
        end
      end
      BRC_ST_REDIRECT: begin
        if (bus.redirect_ready) begin
          redirect_valid_d = 1'b0;
          state_d          = BRC_ST_IDLE;
        end
      end
      default: state_d = BRC_ST_IDLE;
    endcase

    // An older trap wins over everything the branch would have produced.
    if (bus.kill) begin
      state_d          = BRC_ST_IDLE;
      redirect_valid_d = 1'b0;
      done_d           = 1'b0;
      misalign_valid_d = 1'b0;
      misalign_addr_d  = misalign_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= BRC_ST_IDLE;
      pc_q             <= '0;
      imm_q            <= '0;
      cond_q           <= '0;
      jalr_q           <= 1'b0;
      pred_q           <= 1'b0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      rs1_cap_q        <= 1'b0;
      rs2_cap_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misalign_addr_q  <= '0;
      done_q           <= 1'b0;
      misalign_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      imm_q            <= imm_d;
      cond_q           <= cond_d;
      jalr_q           <= jalr_d;
      pred_q           <= pred_d;
      rs1_q            <= rs1_d;
      rs2_q            <= rs2_d;
      rs1_cap_q        <= rs1_cap_d;
      rs2_cap_q        <= rs2_cap_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      misalign_addr_q  <= misalign_addr_d;
      done_q           <= done_d;
      misalign_valid_q <= misalign_valid_d;
    end
  end

  assign bus.br_ready       = (state_q == BRC_ST_IDLE) && !bus.kill;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = handshake;
  assign bus.misalign_valid = misalign_valid_q;
  assign bus.misalign_addr  = misalign_addr_q;
  assign bus.done           = done_q | handshake;

`ifdef ARCHER_BR_PERF_EN
  logic [CNT_W-1:0] perf_br_q, perf_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (done_q | handshake) perf_br_q <= perf_br_q + CNT_W'(1);
      if (handshake)          perf_mp_q <= perf_mp_q + CNT_W'(1);
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed cases plus randomized
// branches checked against an outcome model derived from the branch rules.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  localparam int PRED_MODE = 1;
  localparam int CNT_W     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if bus();
  logic [CNT_W-1:0] perf_branches, perf_mispred;

  branch_resolve_ctrl #(.PRED_MODE(PRED_MODE), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .perf_branches (perf_branches),
    .perf_mispred  (perf_mispred)
  );

  int checks = 0;
  int failures = 0;
  int exp_br = 0;
  int exp_mp = 0;
  logic [31:0] exp_mis_addr = 32'h0;

  // kind: 0 = correctly predicted (done only), 1 = misaligned target, 2 = redirect
  function automatic void model(input bit jalr, input logic [2:0] cond,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] b,
                                output int kind, output logic [31:0] addr);
    bit taken, pred;
    logic [31:0] tgt;
    if (jalr) begin
      taken = 1'b1;
      tgt   = (a + imm) & 32'hFFFF_FFFE;
      pred  = 1'b0;
    end else begin
      case (cond)
        3'd0: taken = (a == b);
        3'd1: taken = (a != b);
        3'd4: taken = ($signed(a) <  $signed(b));
        3'd5: taken = ($signed(a) >= $signed(b));
        3'd6: taken = (a <  b);
        3'd7: taken = (a >= b);
        default: taken = 1'b0;
      endcase
      tgt  = pc + imm;
      pred = (PRED_MODE != 0) ? imm[31] : 1'b0;
    end
    if (taken && tgt[1:0] != 2'b00) begin
      kind = 1; addr = tgt;
    end else if (jalr || taken != pred) begin
      kind = 2; addr = taken ? tgt : pc + 32'd4;
    end else begin
      kind = 0; addr = 32'h0;
    end
  endfunction

  task automatic idle_inputs();
    bus.br_valid = 1'b0; bus.br_is_jalr = 1'b0; bus.br_cond = 3'd0;
    bus.br_pc = '0; bus.br_imm = '0; bus.rs1_val = '0; bus.rs2_val = '0;
    bus.rs1_rdy = 1'b0; bus.rs2_rdy = 1'b0; bus.kill = 1'b0; bus.redirect_ready = 1'b0;
  endtask

  task automatic run_branch(input string name, input bit jalr, input logic [2:0] cond,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input int d1, input int d2, input int stall,
                            input int kill_wait, input bit kill_redir);
    int kind, r;
    logic [31:0] eaddr;
    logic [31:0] pb_exp, pm_exp;
    bit hs;
    model(jalr, cond, pc, imm, v1, v2, kind, eaddr);
    r = jalr ? d1 : ((d1 > d2) ? d1 : d2);
    $display("branch %s jalr=%0b cond=%0d pc=%h imm=%h rs1=%h rs2=%h kind=%0d addr=%h",
             name, jalr, cond, pc, imm, v1, v2, kind, eaddr);

    @(negedge clk);
    idle_inputs();
    bus.br_valid = 1'b1; bus.br_is_jalr = jalr; bus.br_cond = cond;
    bus.br_pc = pc; bus.br_imm = imm;
    #1;
    checks++;
    if (bus.br_ready !== 1'b1) begin
      failures++; $display("FAIL %s accept_ready got=%b exp=1", name, bus.br_ready);
    end

    for (int t = 0; t <= r; t++) begin
      @(negedge clk);
      // Decode-side fields change under the unit: they must already be latched.
      bus.br_valid = 1'($urandom_range(0, 1)); bus.br_is_jalr = 1'($urandom_range(0, 1));
      bus.br_cond = 3'($urandom); bus.br_pc = $urandom; bus.br_imm = $urandom;
      bus.rs1_rdy = (t == d1) ? 1'b1 : ((t > d1) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.rs1_val = (t == d1) ? v1 : $urandom;
      if (jalr) begin
        bus.rs2_rdy = 1'($urandom_range(0, 1)); bus.rs2_val = $urandom;
      end else begin
        bus.rs2_rdy = (t == d2) ? 1'b1 : ((t > d2) ? 1'($urandom_range(0, 1)) : 1'b0);
        bus.rs2_val = (t == d2) ? v2 : $urandom;
      end
      bus.kill = (t == kill_wait);
      #1;
      checks++;
      if ({bus.br_ready, bus.done, bus.redirect_valid, bus.misalign_valid, bus.flush} !== 5'b0) begin
        failures++;
        $display("FAIL %s wait_outputs t=%0d got={rdy,done,rv,mis,flush}=%b exp=00000", name, t,
                 {bus.br_ready, bus.done, bus.redirect_valid, bus.misalign_valid, bus.flush});
      end
      if (t == kill_wait) begin
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({bus.br_ready, bus.done, bus.redirect_valid, bus.misalign_valid, bus.flush} !== 5'b10000) begin
          failures++;
          $display("FAIL %s after_kill got={rdy,done,rv,mis,flush}=%b exp=10000", name,
                   {bus.br_ready, bus.done, bus.redirect_valid, bus.misalign_valid, bus.flush});
        end
        return;
      end
    end

    @(negedge clk);
    idle_inputs();
    if (kind == 2) begin
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) @(negedge clk);
        hs = (s == stall) && !kill_redir;
        bus.redirect_ready = (s == stall);
        bus.kill = (s == stall) && kill_redir;
        bus.br_valid = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== eaddr) begin
          failures++;
          $display("FAIL %s redirect s=%0d got valid=%b pc=%h exp valid=1 pc=%h", name, s,
                   bus.redirect_valid, bus.redirect_pc, eaddr);
        end
        checks++;
        if ({bus.flush, bus.done, bus.br_ready, bus.misalign_valid} !== {hs, hs, 2'b00}) begin
          failures++;
          $display("FAIL %s redirect_hs s=%0d got={flush,done,rdy,mis}=%b exp=%b", name, s,
                   {bus.flush, bus.done, bus.br_ready, bus.misalign_valid}, {hs, hs, 2'b00});
        end
        if (hs) begin exp_br++; exp_mp++; end
      end
    end else begin
      #1;
      checks++;
      if ({bus.done, bus.misalign_valid, bus.redirect_valid, bus.flush} !== {1'b1, (kind == 1), 2'b00}) begin
        failures++;
        $display("FAIL %s outcome got={done,mis,rv,flush}=%b exp=%b", name,
                 {bus.done, bus.misalign_valid, bus.redirect_valid, bus.flush}, {1'b1, (kind == 1), 2'b00});
      end
      exp_br++;
      if (kind == 1) exp_mis_addr = eaddr;
    end

    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({bus.br_ready, bus.done, bus.redirect_valid, bus.misalign_valid, bus.flush} !== 5'b10000) begin
      failures++;
      $display("FAIL %s trailing got={rdy,done,rv,mis,flush}=%b exp=10000", name,
               {bus.br_ready, bus.done, bus.redirect_valid, bus.misalign_valid, bus.flush});
    end
    checks++;
    if (bus.misalign_addr !== exp_mis_addr) begin
      failures++;
      $display("FAIL %s misalign_addr got=%h exp=%h", name, bus.misalign_addr, exp_mis_addr);
    end
`ifdef ARCHER_BR_PERF_EN
    pb_exp = 32'(exp_br); pm_exp = 32'(exp_mp);
`else
    pb_exp = 32'h0; pm_exp = 32'h0;
`endif
    checks++;
    if (perf_branches !== pb_exp || perf_mispred !== pm_exp) begin
      failures++;
      $display("FAIL %s perf got=%0d/%0d exp=%0d/%0d", name, perf_branches, perf_mispred, pb_exp, pm_exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.redirect_valid, bus.flush, bus.misalign_valid, bus.done} !== 4'b0 ||
        bus.redirect_pc !== 32'h0 || bus.misalign_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got={rv,flush,mis,done}=%b pc=%h addr=%h exp=0",
               {bus.redirect_valid, bus.flush, bus.misalign_valid, bus.done}, bus.redirect_pc, bus.misalign_addr);
    end
    checks++;
    if (perf_branches !== '0 || perf_mispred !== '0) begin
      failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_branches, perf_mispred);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.br_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.br_ready);
    end
  endtask

  task automatic test_spec_cases();
    run_branch("bne_mispredict", 1'b0, BR_COND_BNE, 32'h100, 32'h20, 32'd5, 32'd6, 0, 0, 2, -1, 1'b0);
    run_branch("beq_predicted", 1'b0, BR_COND_BEQ, 32'h200, 32'hFFFF_FFF0, 32'd7, 32'd7, 0, 0, 0, -1, 1'b0);
    run_branch("blt_signed", 1'b0, BR_COND_BLT, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 1, 1, -1, 1'b0);
    run_branch("bltu_not_taken", 1'b0, BR_COND_BLTU, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1, 0, 0, -1, 1'b0);
    run_branch("bltu_back_mispred", 1'b0, BR_COND_BLTU, 32'h300, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, -1, 1'b0);
    run_branch("jalr_misalign", 1'b1, 3'd0, 32'h400, 32'h0, 32'h1003, 32'h0, 3, 0, 0, -1, 1'b0);
    run_branch("jalr_aligned", 1'b1, 3'd0, 32'h404, 32'h10, 32'h2001, 32'h0, 1, 0, 1, -1, 1'b0);
    run_branch("reserved_cond", 1'b0, 3'b010, 32'h500, 32'h8, 32'd3, 32'd3, 0, 2, 0, -1, 1'b0);
    run_branch("kill_redirect", 1'b0, BR_COND_BNE, 32'h600, 32'h10, 32'd1, 32'd2, 0, 0, 4, -1, 1'b1);
    run_branch("kill_wait", 1'b0, BR_COND_BEQ, 32'h700, 32'h10, 32'd4, 32'd4, 2, 1, 0, 1, 1'b0);
    run_branch("kill_at_resolve", 1'b0, BR_COND_BEQ, 32'h800, 32'h10, 32'd4, 32'd4, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_kill_idle();
    @(negedge clk);
    idle_inputs();
    bus.br_valid = 1'b1; bus.kill = 1'b1; bus.br_pc = 32'h900;
    #1;
    checks++;
    if (bus.br_ready !== 1'b0) begin
      failures++; $display("FAIL kill_idle_ready got=%b exp=0", bus.br_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({bus.br_ready, bus.done, bus.redirect_valid} !== 3'b100) begin
      failures++;
      $display("FAIL kill_idle_after got={rdy,done,rv}=%b exp=100", {bus.br_ready, bus.done, bus.redirect_valid});
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, imm, v1, v2;
    bit jalr;
    for (int i = 0; i < 60; i++) begin
      jalr = ($urandom_range(0, 3) == 0);
      pc = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 127) * 4) - 32'd256;
        1: imm = 32'($urandom_range(0, 127) * 2) - 32'd128;
        2: imm = $urandom;
        default: imm = 32'hFFFF_F000 | ($urandom & 32'hFFC);
      endcase
      v1 = $urandom;
      v2 = ($urandom_range(0, 2) == 0) ? v1 : $urandom;
      run_branch($sformatf("rand%0d", i), jalr, 3'($urandom), pc, imm, v1, v2,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                 ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_perf();
    logic [31:0] pb_exp, pm_exp;
    @(negedge clk);
    #1;
`ifdef ARCHER_BR_PERF_EN
    pb_exp = 32'(exp_br); pm_exp = 32'(exp_mp);
`else
    pb_exp = 32'h0; pm_exp = 32'h0;
`endif
    checks++;
    if (perf_branches !== pb_exp || perf_mispred !== pm_exp) begin
      failures++;
      $display("FAIL perf_final got=%0d/%0d exp=%0d/%0d", perf_branches, perf_mispred, pb_exp, pm_exp);
    end
  endtask

  initial begin
    test_reset();
    test_spec_cases();
    test_kill_idle();
    test_random();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
